// File: rtl/arm_fetch_pkg.sv
// Shared types for the ARM fetch front end: the {pc, instr} prefetch entry and fetch constants.
// Latency: n/a (types only). Backpressure: n/a.
package arm_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int WORD_BYTES = 4;
    localparam int PC_PLUS8   = 8;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/arm_fetch_fifo.sv
// Prefetch FIFO of fetch entries; flush beats push. Latency: a push is visible at the head the next cycle.
// Backpressure: none internally; the producer must never push when full.
module arm_fetch_fifo
    import arm_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_dat,
    input  logic                         pop,
    output fetch_entry_t                 head_dat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !flush;
        do_pop   = pop && !empty && !flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/arm_fetch_unit.sv
// Sequential instruction fetch into a prefetch FIFO, handed to decode; redirect flushes and refetches.
// Latency: dec_valid 2 cycles after imem_req. Backpressure: dec_ready low stalls issue once FIFO+inflight fill.
module arm_fetch_unit
    import arm_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc_plus8,
    output logic [31:0] PC
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      issued_pc_q, issued_pc_d;
    logic             inflight_q, inflight_d;
    logic             kill_q, kill_d;
    logic             issue, push, pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0] occupancy;
    fetch_entry_t     push_dat, head_dat;

    always_comb begin
        // Reserve a slot for the word still in flight so a returning push always fits.
        occupancy      = OCC_W'(fifo_count) + OCC_W'(inflight_q);
        issue          = !reset && !redirect_valid && (occupancy < OCC_W'(DEPTH));
        push           = inflight_q && !kill_q;
        push_dat.pc    = issued_pc_q;
        push_dat.instr = imem_rdata;
        fetch_pc_d     = fetch_pc_q;
        issued_pc_d    = issued_pc_q;
        inflight_d     = issue;
        kill_d         = redirect_valid;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_target);
        end else if (issue) begin
            fetch_pc_d  = fetch_pc_q + 32'(WORD_BYTES);
            issued_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            kill_q      <= kill_d;
        end
    end

    arm_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign imem_req     = issue;
    assign imem_addr    = fetch_pc_q;
    assign PC           = fetch_pc_q;
    assign dec_valid    = !fifo_empty && !redirect_valid && !reset;
    assign pop          = dec_valid && dec_ready;
    assign dec_pc       = fifo_empty ? '0 : head_dat.pc;
    assign dec_instr    = fifo_empty ? '0 : head_dat.instr;
    assign dec_pc_plus8 = dec_pc + 32'(PC_PLUS8);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full && !redirect_valid));

endmodule
